// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction store: packs big-endian bytes into 32-bit words,
// writes them at byte addresses 0, 4, 8, ... and holds the CPU until the load completes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start after reset; nothing loaded yet
// S_RECV  | accepting bytes of the current word (byte_ready high)
// S_WRITE | single-cycle write strobe of the assembled word
// S_DONE  | load finished; CPU released, waiting for a new start
module instr_mem_loader #(
  parameter int DEPTH = 65,
  parameter int CNT_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_word_count,
  input  logic [7:0]       i_byte_in,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic             o_cpu_hold,
  output logic             o_done,
  output logic             o_error
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_index;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_shift;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic             r_error;
  logic             w_start_ok;
  logic             w_start_bad;
  logic             w_accept;
  logic             w_last_word;

  assign w_accept    = o_byte_ready & i_byte_valid;
  assign w_last_word = (r_index + CNT_W'(1)) == r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_byte_ready = 1'b0;
    o_mem_we     = 1'b0;
    o_cpu_hold   = 1'b0;
    o_done       = 1'b0;
    w_start_ok   = 1'b0;
    w_start_bad  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        o_done = (r_state == S_DONE);
        if (i_start) begin
          if (i_word_count == '0) begin
            w_next = S_DONE;
          end else if (i_word_count > DEPTH_C) begin
            w_start_bad = 1'b1;
          end else begin
            w_start_ok = 1'b1;
            w_next     = S_RECV;
          end
        end
      end
      S_RECV: begin
        o_byte_ready = 1'b1;
        o_cpu_hold   = 1'b1;
        if (w_accept && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        o_mem_we   = 1'b1;
        o_cpu_hold = 1'b1;
        w_next     = w_last_word ? S_DONE : S_RECV;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address/data are captured with the 4th byte so they are stable through WRITE and held after.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count     <= '0;
      r_index     <= '0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_error     <= 1'b0;
    end else begin
      r_error <= w_start_bad;
      if (w_start_ok) begin
        r_count    <= i_word_count;
        r_index    <= '0;
        r_byte_cnt <= '0;
      end
      if (w_accept) begin
        r_shift    <= {r_shift[15:0], i_byte_in};
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == 2'd3) begin
          r_mem_wdata <= {r_shift, i_byte_in};
          r_mem_addr  <= {{(32-CNT_W-2){1'b0}}, r_index, 2'b00};
        end
      end
      if (r_state == S_WRITE) begin
        r_index    <= r_index + CNT_W'(1);
        r_byte_cnt <= '0;
      end
    end
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_error     = r_error;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: expected writes queued as bytes are driven,
// popped and compared by a monitor on every mem_we.
module tb_instr_mem_loader;

  localparam int CNT_W = 7;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic [CNT_W-1:0] i_word_count;
  logic [7:0]       i_byte_in;
  logic             i_byte_valid;
  logic             o_byte_ready;
  logic             o_mem_we;
  logic [31:0]      o_mem_addr;
  logic [31:0]      o_mem_wdata;
  logic             o_cpu_hold;
  logic             o_done;
  logic             o_error;

  instr_mem_loader #(.DEPTH(65), .CNT_W(CNT_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_word_count (i_word_count),
    .i_byte_in    (i_byte_in),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_cpu_hold   (o_cpu_hold),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          c0       = 0;
  logic [63:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] cnt);
    i_start      = 1'b1;
    i_word_count = cnt;
    step();
    i_start = 1'b0;
    c0      = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    bit acc;
    if (gap) begin
      i_byte_valid = 1'b0;
      step();
    end
    i_byte_in    = b;
    i_byte_valid = 1'b1;
    t            = 0;
    do begin
      acc = o_byte_ready;
      step();
      t++;
    end while (!acc && t < 40);
    chk("byte_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gap);
    q.push_back({addr, w});
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!o_done && t < 100) begin
      step();
      t++;
    end
    chk("done_reached", 32'(o_done), 32'd1);
    chk("hold_released", 32'(o_cpu_hold), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
    chk({tag, "_we"},    32'(o_mem_we),     32'd0);
    chk({tag, "_addr"},  o_mem_addr,        32'd0);
    chk({tag, "_wdata"}, o_mem_wdata,       32'd0);
    chk({tag, "_hold"},  32'(o_cpu_hold),   32'd0);
    chk({tag, "_done"},  32'(o_done),       32'd0);
    chk({tag, "_error"}, 32'(o_error),      32'd0);
  endtask

  always @(negedge i_clk) begin
    if (o_mem_we === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_we", 32'(o_mem_we), 32'd0);
      end else begin
        logic [63:0] e;
        e = q.pop_front();
        chk("wr_addr", o_mem_addr, e[63:32]);
        chk("wr_data", o_mem_wdata, e[31:0]);
        chk("wr_hold", 32'(o_cpu_hold), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst        = 1'b1;
    i_start      = 1'b0;
    i_word_count = '0;
    i_byte_in    = '0;
    i_byte_valid = 1'b0;
    #1;
    chk_all_zero("reset");
    step();
    step();
    i_rst = 1'b0;
    step();
    chk_all_zero("idle");

    // Two words, valid held high: 10 cycles from start to done
    do_start(7'd2);
    chk("load_hold", 32'(o_cpu_hold), 32'd1);
    chk("load_ready", 32'(o_byte_ready), 32'd1);
    send_word(32'h20010005, 32'h0, 1'b0);
    send_word(32'h8C020004, 32'h4, 1'b0);
    chk("last_we", 32'(o_mem_we), 32'd1);
    chk("done_before_end", 32'(o_done), 32'd0);
    step();
    i_byte_valid = 1'b0;
    chk("cycles_to_done", 32'(cyc - c0), 32'd10);
    chk("done_after", 32'(o_done), 32'd1);
    chk("hold_after", 32'(o_cpu_hold), 32'd0);

    // Back-pressure with alternating gaps; start from DONE clears done
    do_start(7'd2);
    chk("restart_done_low", 32'(o_done), 32'd0);
    send_word(32'h20010005, 32'h0, 1'b1);
    send_word(32'h8C020004, 32'h4, 1'b1);
    i_byte_valid = 1'b0;
    wait_done();

    // Junk byte presented during WRITE must not be consumed
    do_start(7'd2);
    send_word(32'h11223344, 32'h0, 1'b0);
    i_byte_in    = 8'hEE;
    i_byte_valid = 1'b1;
    chk("write_ready_low", 32'(o_byte_ready), 32'd0);
    chk("write_we", 32'(o_mem_we), 32'd1);
    step();
    send_word(32'h55667788, 32'h4, 1'b0);
    i_byte_valid = 1'b0;
    wait_done();

    // count=0 from IDLE goes straight to DONE
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    do_start(7'd0);
    chk("zero_done", 32'(o_done), 32'd1);
    chk("zero_hold", 32'(o_cpu_hold), 32'd0);

    // count=66 rejected: one-cycle error, state unchanged
    do_start(7'd66);
    chk("over_error", 32'(o_error), 32'd1);
    chk("over_done", 32'(o_done), 32'd1);
    chk("over_ready", 32'(o_byte_ready), 32'd0);
    step();
    chk("over_error_pulse", 32'(o_error), 32'd0);
    chk("over_done_kept", 32'(o_done), 32'd1);

    // Full depth: 65 words, last at 0x100
    do_start(7'd65);
    for (int i = 0; i < 65; i++) send_word($urandom, 32'(i * 4), 1'b0);
    i_byte_valid = 1'b0;
    wait_done();
    chk("full_last_addr", o_mem_addr, 32'h100);

    // Async reset mid-load, then a fresh single-word load
    do_start(7'd3);
    send_word(32'hCAFEF00D, 32'h0, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    #2;
    i_rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    step();
    step();
    i_rst = 1'b0;
    i_byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("post_reset_hold", 32'(o_cpu_hold), 32'd0);
    chk("post_reset_done", 32'(o_done), 32'd0);
    i_byte_valid = 1'b0;
    do_start(7'd1);
    send_word(32'hAABBCCDD, 32'h0, 1'b0);
    i_byte_valid = 1'b0;
    wait_done();

    // Start pulse during RECV is ignored
    do_start(7'd2);
    q.push_back({32'h0, 32'h0BADBEEF});
    send_byte(8'h0B, 1'b0);
    send_byte(8'hAD, 1'b0);
    i_byte_valid = 1'b0;
    i_start      = 1'b1;
    i_word_count = 7'd5;
    step();
    i_start = 1'b0;
    chk("recv_start_hold", 32'(o_cpu_hold), 32'd1);
    chk("recv_start_error", 32'(o_error), 32'd0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_word(32'h13579BDF, 32'h4, 1'b0);
    i_byte_valid = 1'b0;
    wait_done();

    // Start in DONE with count=1 restarts from address 0
    do_start(7'd1);
    chk("done_drop", 32'(o_done), 32'd0);
    chk("done_restart_hold", 32'(o_cpu_hold), 32'd1);
    send_word(32'hDEADBEEF, 32'h0, 1'b0);
    i_byte_valid = 1'b0;
    wait_done();

    step();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
